mac_output_packer: RTL and testbench

//  Output stage directly downstream of mac_psum_accumulator. Consumes its FP32 result stream over valid/ready.

---
 rtl/mac_output_packer.sv | 121 ++++++++++++
 tb/tb_mac_output_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_output_packer.sv
// mac_output_packer: optional ReLU per FP32 beat, packs PACK_N beats into one
// wide word (early close on i_last) and buffers packed words in a small FIFO.
module mac_output_packer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PACK_N     = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_relu_enable,
    input  logic                     mac_output_packer_i_valid,
    output logic                     mac_output_packer_o_ready,
    input  logic [DATA_W-1:0]        mac_output_packer_i_data,
    input  logic                     mac_output_packer_i_last,
    output logic                     mac_output_packer_o_valid,
    input  logic                     mac_output_packer_i_ready,
    output logic [DATA_W*PACK_N-1:0] mac_output_packer_o_data,
    output logic [PACK_N-1:0]        mac_output_packer_o_mask,
    output logic                     mac_output_packer_o_last
);

    localparam int unsigned WORD_W = DATA_W * PACK_N;
    localparam int unsigned CNT_W  = $clog2(PACK_N);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              last;
        logic [PACK_N-1:0] mask;
        logic [WORD_W-1:0] data;
    } entry_t;

    // Packing state
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_word;
    logic [PACK_N-1:0] r_mask;

    // FIFO state
    entry_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FCNT_W-1:0] r_count;

    logic              w_accept;
    logic              w_close;
    logic              w_pop;
    logic [DATA_W-1:0] w_lane_val;
    logic [WORD_W-1:0] w_word_next;
    logic [PACK_N-1:0] w_mask_next;
    logic [PTR_W-1:0]  w_wr_ptr_inc;
    logic [PTR_W-1:0]  w_rd_ptr_inc;

    assign mac_output_packer_o_ready = !i_reset && (r_count < FCNT_W'(FIFO_DEPTH));
    assign mac_output_packer_o_valid = (r_count != '0);
    assign mac_output_packer_o_data  = r_mem[r_rd_ptr].data;
    assign mac_output_packer_o_mask  = r_mem[r_rd_ptr].mask;
    assign mac_output_packer_o_last  = r_mem[r_rd_ptr].last;

    assign w_accept = mac_output_packer_i_valid && mac_output_packer_o_ready;
    assign w_pop    = mac_output_packer_o_valid && mac_output_packer_i_ready;
    assign w_close  = w_accept && ((r_cnt == CNT_W'(PACK_N - 1)) || mac_output_packer_i_last);

    assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    // ReLU on the sign bit only, then merge the beat into the current lane
    always_comb begin
        w_lane_val  = mac_output_packer_i_data;
        w_word_next = r_word;
        w_mask_next = r_mask | (PACK_N'(1) << r_cnt);
        if (i_relu_enable && mac_output_packer_i_data[DATA_W-1]) begin
            w_lane_val = '0;
        end
        w_word_next[32'(r_cnt) * DATA_W +: DATA_W] = w_lane_val;
    end

    // Lane counter and partial word; cleared whenever a word closes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_mask <= '0;
        end else if (w_close) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_mask <= '0;
        end else if (w_accept) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_word <= w_word_next;
            r_mask <= w_mask_next;
        end
    end

    // Packed-word FIFO; push is only possible when not full because of o_ready
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_close) begin
                r_mem[r_wr_ptr] <= '{last: mac_output_packer_i_last,
                                     mask: w_mask_next,
                                     data: w_word_next};
                r_wr_ptr        <= w_wr_ptr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_close && !w_pop) begin
                r_count <= r_count + FCNT_W'(1);
            end else if (w_pop && !w_close) begin
                r_count <= r_count - FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_output_packer.sv
// Self-checking bench for mac_output_packer (DATA_W=32, PACK_N=4, FIFO_DEPTH=2).
module tb_mac_output_packer;

    logic         clk;
    logic         i_reset;
    logic         i_relu_enable;
    logic         i_valid;
    logic         o_ready;
    logic [31:0]  i_data;
    logic         i_last;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;
    logic [3:0]   o_mask;
    logic         o_last;

    mac_output_packer #(.DATA_W(32), .PACK_N(4), .FIFO_DEPTH(2)) dut (
        .i_clk                     (clk),
        .i_reset                   (i_reset),
        .i_relu_enable             (i_relu_enable),
        .mac_output_packer_i_valid (i_valid),
        .mac_output_packer_o_ready (o_ready),
        .mac_output_packer_i_data  (i_data),
        .mac_output_packer_i_last  (i_last),
        .mac_output_packer_o_valid (o_valid),
        .mac_output_packer_i_ready (i_ready),
        .mac_output_packer_o_data  (o_data),
        .mac_output_packer_o_mask  (o_mask),
        .mac_output_packer_o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic relu; logic [31:0] data; logic last; } beat_t;
    typedef struct { logic [127:0] data; logic [3:0] mask; logic last; } word_t;

    int     checks = 0;
    int     errors = 0;
    word_t  got[$];
    word_t  mq[$];
    beat_t  beats[18];
    word_t  exp_w[6];

    // reference model state for the random phase
    int          mcnt = 0;
    logic [127:0] mword = '0;
    logic [3:0]   mmask = '0;
    logic [31:0]  mval;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // output monitor: word is taken at the next rising edge
    always @(negedge clk) begin
        if (!i_reset && o_valid && i_ready)
            got.push_back('{o_data, o_mask, o_last});
    end

    // reference model: beat accepted at the next rising edge
    always @(negedge clk) begin
        if (i_reset) begin
            mcnt  = 0;
            mword = '0;
            mmask = '0;
        end else if (i_valid && o_ready) begin
            mval = (i_relu_enable && i_data[31]) ? 32'h0 : i_data;
            mword[mcnt*32 +: 32] = mval;
            mmask[mcnt] = 1'b1;
            if (mcnt == 3 || i_last) begin
                mq.push_back('{mword, mmask, i_last});
                mcnt  = 0;
                mword = '0;
                mmask = '0;
            end else begin
                mcnt++;
            end
        end
    end

    // present one beat and hold it until accepted (bounded)
    task automatic send(input logic relu, input logic [31:0] d, input logic last);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        i_valid = 1'b1; i_data = d; i_last = last; i_relu_enable = relu;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic idle(input int cycles);
        i_valid = 1'b0; i_last = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    task automatic cmp_word(input string name, input word_t a, input word_t e);
        chk({name, "_data"}, a.data, e.data);
        chk({name, "_mask"}, 128'(a.mask), 128'(e.mask));
        chk({name, "_last"}, 128'(a.last), 128'(e.last));
    endtask

    initial begin
        int acc_cnt;
        int n;
        logic acc;

        i_reset = 1'b1; i_relu_enable = 1'b0; i_valid = 1'b0;
        i_data = '0; i_last = 1'b0; i_ready = 1'b1;

        // directed vectors: beats and the words they must produce
        beats[0]  = '{1'b1, 32'h3F800000, 1'b0};
        beats[1]  = '{1'b1, 32'hC0000000, 1'b0};
        beats[2]  = '{1'b1, 32'h40400000, 1'b0};
        beats[3]  = '{1'b1, 32'hC0800000, 1'b0};
        beats[4]  = '{1'b1, 32'h40A00000, 1'b0};
        beats[5]  = '{1'b1, 32'h40C00000, 1'b0};
        beats[6]  = '{1'b1, 32'h40E00000, 1'b0};
        beats[7]  = '{1'b1, 32'h41000000, 1'b0};
        beats[8]  = '{1'b0, 32'hC0000000, 1'b0};
        beats[9]  = '{1'b0, 32'h80000000, 1'b1};
        beats[10] = '{1'b1, 32'h3F800000, 1'b0};
        beats[11] = '{1'b1, 32'h40000000, 1'b0};
        beats[12] = '{1'b1, 32'h40400000, 1'b1};
        beats[13] = '{1'b1, 32'h40800000, 1'b1};
        beats[14] = '{1'b1, 32'h41100000, 1'b0};
        beats[15] = '{1'b1, 32'h41200000, 1'b0};
        beats[16] = '{1'b1, 32'h41300000, 1'b0};
        beats[17] = '{1'b1, 32'h41400000, 1'b1};
        exp_w[0] = '{{32'h0, 32'h40400000, 32'h0, 32'h3F800000}, 4'hF, 1'b0};
        exp_w[1] = '{{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000}, 4'hF, 1'b0};
        exp_w[2] = '{{32'h0, 32'h0, 32'h80000000, 32'hC0000000}, 4'h3, 1'b1};
        exp_w[3] = '{{32'h0, 32'h40400000, 32'h40000000, 32'h3F800000}, 4'h7, 1'b1};
        exp_w[4] = '{{32'h0, 32'h0, 32'h0, 32'h40800000}, 4'h1, 1'b1};
        exp_w[5] = '{{32'h41400000, 32'h41300000, 32'h41200000, 32'h41100000}, 4'hF, 1'b1};

        // reset values
        repeat (2) @(posedge clk); #1;
        @(negedge clk);
        chk("rst_o_valid", 128'(o_valid), 128'(0));
        chk("rst_o_data",  o_data, 128'(0));
        chk("rst_o_mask",  128'(o_mask), 128'(0));
        chk("rst_o_last",  128'(o_last), 128'(0));
        chk("rst_o_ready", 128'(o_ready), 128'(0));
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        chk("post_rst_o_ready", 128'(o_ready), 128'(1));
        @(posedge clk); #1;

        // table-driven packing, ReLU, bit-exact passthrough, early close
        got.delete();
        for (int i = 0; i < 18; i++) send(beats[i].relu, beats[i].data, beats[i].last);
        idle(8);
        chk("table_word_count", 128'(got.size()), 128'(6));
        for (int i = 0; i < 6 && i < got.size(); i++)
            cmp_word($sformatf("table_w%0d", i), got[i], exp_w[i]);

        // back-pressure: FIFO fills, o_ready drops, then drains in order
        got.delete();
        i_ready = 1'b0; acc_cnt = 0;
        i_valid = 1'b1; i_last = 1'b0; i_relu_enable = 1'b0; i_data = 32'h100;
        repeat (20) begin
            @(negedge clk);
            acc = i_valid && o_ready;
            @(posedge clk); #1;
            if (acc) begin acc_cnt++; i_data = 32'h100 + 32'(acc_cnt); end
        end
        i_valid = 1'b0;
        @(negedge clk);
        chk("stall_accepted", 128'(acc_cnt), 128'(8));
        chk("stall_o_ready",  128'(o_ready), 128'(0));
        chk("stall_o_valid",  128'(o_valid), 128'(1));
        chk("stall_no_pop",   128'(got.size()), 128'(0));
        @(posedge clk); #1;
        i_ready = 1'b1;
        idle(6);
        chk("drain_count", 128'(got.size()), 128'(2));
        if (got.size() >= 2) begin
            cmp_word("drain_w0", got[0], '{{32'h103, 32'h102, 32'h101, 32'h100}, 4'hF, 1'b0});
            cmp_word("drain_w1", got[1], '{{32'h107, 32'h106, 32'h105, 32'h104}, 4'hF, 1'b0});
        end

        // reset mid-word with one word held in the FIFO
        got.delete();
        i_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(1'b0, 32'hA0 + 32'(i), 1'b0);
        i_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_o_valid", 128'(o_valid), 128'(1));
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_o_ready", 128'(o_ready), 128'(0));
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_o_valid", 128'(o_valid), 128'(0));
        chk("mid_rst_o_ready_after", 128'(o_ready), 128'(1));
        @(posedge clk); #1;
        i_ready = 1'b1;
        send(1'b0, 32'h11, 1'b0); send(1'b0, 32'h22, 1'b0);
        send(1'b0, 32'h33, 1'b0); send(1'b0, 32'h44, 1'b0);
        idle(6);
        chk("rst_fresh_count", 128'(got.size()), 128'(1));
        if (got.size() >= 1)
            cmp_word("rst_fresh_w", got[0], '{{32'h44, 32'h33, 32'h22, 32'h11}, 4'hF, 1'b0});

        // random traffic against the reference model
        got.delete(); mq.delete();
        acc_cnt = 0; n = 0;
        while (acc_cnt < 1000 && n < 20000) begin
            i_valid       = ($urandom_range(3) != 0);
            i_data        = $urandom;
            i_last        = ($urandom_range(5) == 0);
            i_relu_enable = $urandom_range(1);
            i_ready       = ($urandom_range(2) != 0);
            @(negedge clk);
            acc = i_valid && o_ready;
            @(posedge clk); #1;
            if (acc) acc_cnt++;
            n++;
        end
        if (acc_cnt < 1000) begin
            checks++; errors++;
            $display("FAIL rand_timeout: accepted %0d of 1000 beats", acc_cnt);
        end
        i_ready = 1'b1;
        send(1'b0, 32'h12345678, 1'b1);
        idle(10);
        chk("rand_word_count", 128'(got.size()), 128'(mq.size()));
        for (int i = 0; i < got.size() && i < mq.size(); i++) begin
            checks++;
            if (got[i] != mq[i]) begin
                errors++;
                $display("FAIL rand_w%0d: got %h/%h/%b expected %h/%h/%b", i,
                         got[i].data, got[i].mask, got[i].last,
                         mq[i].data, mq[i].mask, mq[i].last);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
